// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle between the command-driven master and a responder.
// Master modport drives AW/W/AR channels and B/R ready; slave modport is the mirror.
interface axi4lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a cmd/rsp handshake.
// Define AXI4LITE_MASTER_TIMEOUT_EN to add a per-transaction watchdog (TIMEOUT_CYCLES).
module axi4lite_master #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  axi4lite_master_if.master     axi
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] WR_RESP      = 3'd2;
  localparam logic [2:0] RD_ADDR      = 3'd3;
  localparam logic [2:0] RD_DATA      = 3'd4;
  localparam logic [2:0] RSP          = 3'd5;

  logic [2:0] state_q, state_d;
  logic       cmd_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic       aw_pending, w_pending, timeout_hit;

  // Gated by ARESETN so cmd_ready is low during reset yet high right after release.
  assign cmd_ready  = ARESETN && (state_q == IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign b_fire     = axi.BVALID && axi.BREADY;
  assign ar_fire    = axi.ARVALID && axi.ARREADY;
  assign r_fire     = axi.RVALID && axi.RREADY;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign aw_pending = axi.AWVALID && !axi.AWREADY;
  assign w_pending  = axi.WVALID && !axi.WREADY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:         if (cmd_fire) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (!aw_pending && !w_pending) state_d = WR_RESP;
      WR_RESP:      if (b_fire) state_d = RSP;
      RD_ADDR:      if (ar_fire) state_d = RD_DATA;
      RD_DATA:      if (r_fire) state_d = RSP;
      RSP:          if (rsp_fire) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    if (timeout_hit) state_d = RSP;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      axi.AWADDR  <= '0;
      axi.AWVALID <= 1'b0;
      axi.WDATA   <= '0;
      axi.WSTRB   <= '0;
      axi.WVALID  <= 1'b0;
      axi.BREADY  <= 1'b0;
      axi.ARADDR  <= '0;
      axi.ARVALID <= 1'b0;
      axi.RREADY  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_fire && cmd_write) begin
            axi.AWADDR  <= cmd_addr;
            axi.WDATA   <= cmd_wdata;
            axi.WSTRB   <= cmd_wstrb;
            axi.AWVALID <= 1'b1;
            axi.WVALID  <= 1'b1;
          end else if (cmd_fire) begin
            axi.ARADDR  <= cmd_addr;
            axi.ARVALID <= 1'b1;
          end
        end
        WR_ADDR_DATA: begin
          if (axi.AWREADY) axi.AWVALID <= 1'b0;
          if (axi.WREADY) axi.WVALID <= 1'b0;
          if (state_d == WR_RESP) axi.BREADY <= 1'b1;
        end
        WR_RESP: begin
          if (b_fire) begin
            axi.BREADY <= 1'b0;
            rsp_resp   <= axi.BRESP;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (ar_fire) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_fire) begin
            axi.RREADY <= 1'b0;
            rsp_rdata  <= axi.RDATA;
            rsp_resp   <= axi.RRESP;
            rsp_valid  <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_fire) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
      // Watchdog abandons the bus transaction and reports SLVERR.
      if (timeout_hit) begin
        axi.AWVALID <= 1'b0;
        axi.WVALID  <= 1'b0;
        axi.BREADY  <= 1'b0;
        axi.ARVALID <= 1'b0;
        axi.RREADY  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= '0;
      end
    end
  end

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        busy, rsp_timeout_q;

  assign busy        = (state_q != IDLE) && (state_q != RSP);
  // cnt_q is 1 in the first cycle after acceptance, so the hit lands TIMEOUT_CYCLES in.
  assign timeout_hit = busy && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (cmd_fire) cnt_q <= 16'd1;
      else if (state_d == RSP) cnt_q <= '0;
      else if (busy) cnt_q <= cnt_q + 16'd1;
      if (timeout_hit) rsp_timeout_q <= 1'b1;
      else if (rsp_fire) rsp_timeout_q <= 1'b0;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign rsp_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed self-checking bench for axi4lite_master; the responder is scripted per test.
module tb_axi4lite_master;
  logic        ACLK;
  logic        ARESETN;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  int errors = 0;
  int checks = 0;

  axi4lite_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  axi4lite_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .axi        (bus)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.BVALID = 1'b0; bus.BRESP = '0;
    bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0; bus.RRESP = '0;
    tick; tick;
    checks++;
    if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
         rsp_valid, rsp_timeout, cmd_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY,
                rsp_valid, rsp_timeout, cmd_ready});
    end
    checks++;
    if ({bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, rsp_rdata, rsp_resp} !== 82'd0) begin
      errors++;
      $display("FAIL reset_data: got %h required 0",
               {bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, rsp_rdata, rsp_resp});
    end
    ARESETN = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_cmd_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h0000_00A5;
    cmd_wstrb = 4'hF;
    tick;
    cmd_valid = 1'b0;
    checks++;
    if ({bus.AWVALID, bus.WVALID} !== 2'b11) begin
      errors++;
      $display("FAIL wr_valids_raised: got %b required 11", {bus.AWVALID, bus.WVALID});
    end
    bus.WREADY = 1'b1;
    tick;
    bus.WREADY = 1'b0;
    checks++;
    if ({bus.AWVALID, bus.WVALID} !== 2'b10) begin
      errors++;
      $display("FAIL wr_w_dropped: got %b required 10", {bus.AWVALID, bus.WVALID});
    end
    bus.AWREADY = 1'b1;
    tick;
    bus.AWREADY = 1'b0;
    checks++;
    if ({bus.AWVALID, bus.BREADY} !== 2'b01) begin
      errors++;
      $display("FAIL wr_bready: got %b required 01", {bus.AWVALID, bus.BREADY});
    end
    checks++;
    if ({bus.AWADDR, bus.WDATA, bus.WSTRB} !== {4'h0, 32'h0000_00A5, 4'hF}) begin
      errors++;
      $display("FAIL wr_addr_data_held: got %h required 00000a5f",
               {bus.AWADDR, bus.WDATA, bus.WSTRB});
    end
    bus.BVALID = 1'b1; bus.BRESP = 2'b00;
    tick;
    bus.BVALID = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp, rsp_rdata, bus.BREADY} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL wr_rsp: got v=%b resp=%b rdata=%h bready=%b required v=1 resp=00 rdata=0 bready=0",
               rsp_valid, rsp_resp, rsp_rdata, bus.BREADY);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_rsp_done: got %b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_read;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
    tick;
    cmd_valid = 1'b0;
    checks++;
    if ({bus.ARVALID, bus.ARADDR} !== {1'b1, 4'h8}) begin
      errors++;
      $display("FAIL rd_arvalid: got v=%b addr=%h required v=1 addr=8", bus.ARVALID, bus.ARADDR);
    end
    bus.ARREADY = 1'b1;
    tick;
    bus.ARREADY = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.ARVALID, bus.RREADY, bus.ARADDR, rsp_valid} !== {1'b0, 1'b1, 4'h8, 1'b0}) begin
        errors++;
        $display("FAIL rd_wait%0d: got arv=%b rr=%b addr=%h rv=%b required arv=0 rr=1 addr=8 rv=0",
                 i, bus.ARVALID, bus.RREADY, bus.ARADDR, rsp_valid);
      end
      tick;
    end
    bus.RVALID = 1'b1; bus.RDATA = 32'h0000_0002; bus.RRESP = 2'b00;
    checks++;
    if (bus.ARADDR !== 4'h8) begin
      errors++;
      $display("FAIL rd_addr_at_rvalid: got %h required 8", bus.ARADDR);
    end
    tick;
    bus.RVALID = 1'b0;
    checks++;
    if ({rsp_valid, rsp_resp, rsp_rdata, rsp_timeout} !== {1'b1, 2'b00, 32'h2, 1'b0}) begin
      errors++;
      $display("FAIL rd_rsp: got v=%b resp=%b rdata=%h to=%b required v=1 resp=00 rdata=2 to=0",
               rsp_valid, rsp_resp, rsp_rdata, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  task automatic test_write_w_first;
    int bcnt = 0;
    int rcnt = 0;
    logic [31:0] rdata_seen = 32'hFFFF_FFFF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h1234_5678;
    cmd_wstrb = 4'h3;
    tick;
    cmd_valid = 1'b0;
    bus.WREADY = 1'b1;
    tick;
    bus.WREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.AWVALID, bus.WVALID, bus.AWADDR} !== {1'b1, 1'b0, 4'h4}) begin
        errors++;
        $display("FAIL wf_aw_wait%0d: got awv=%b wv=%b addr=%h required awv=1 wv=0 addr=4",
                 i, bus.AWVALID, bus.WVALID, bus.AWADDR);
      end
      if (i == 2) bus.AWREADY = 1'b1;
      tick;
    end
    bus.AWREADY = 1'b0;
    bus.BVALID = 1'b1; bus.BRESP = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.BVALID && bus.BREADY) bcnt++;
      if (rsp_valid && rsp_ready) begin
        rcnt++;
        rdata_seen = rsp_rdata;
      end
      tick;
      if (bcnt != 0) bus.BVALID = 1'b0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (bcnt !== 1) begin
      errors++;
      $display("FAIL wf_b_count: got %0d required 1", bcnt);
    end
    checks++;
    if (rcnt !== 1) begin
      errors++;
      $display("FAIL wf_rsp_count: got %0d required 1", rcnt);
    end
    checks++;
    if (rdata_seen !== 32'h0) begin
      errors++;
      $display("FAIL wf_rdata_zero: got %h required 0", rdata_seen);
    end
  endtask

  task automatic test_error_hold;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC;
    tick;
    cmd_valid = 1'b0;
    bus.ARREADY = 1'b1;
    tick;
    bus.ARREADY = 1'b0;
    bus.RVALID = 1'b1; bus.RDATA = 32'hDEAD_BEEF; bus.RRESP = 2'b10;
    tick;
    bus.RVALID = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, cmd_ready} !==
          {1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL err_hold%0d: got v=%b resp=%b rdata=%h to=%b cr=%b required v=1 resp=10 rdata=deadbeef to=0 cr=0",
                 i, rsp_valid, rsp_resp, rsp_rdata, rsp_timeout, cmd_ready);
      end
      tick;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL err_release: got %b required 01", {rsp_valid, cmd_ready});
    end
  endtask

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    int lat = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
    while (!rsp_valid && lat < 40) begin
      tick;
      cmd_valid = 1'b0;
      lat++;
    end
    checks++;
    if (lat !== 16) begin
      errors++;
      $display("FAIL to_latency: got %0d required 16", lat);
    end
    checks++;
    if ({bus.ARVALID, rsp_resp, rsp_timeout, rsp_rdata} !== {1'b0, 2'b10, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL to_rsp: got arv=%b resp=%b to=%b rdata=%h required arv=0 resp=10 to=1 rdata=0",
               bus.ARVALID, rsp_resp, rsp_timeout, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_timeout, cmd_ready} !== 3'b001) begin
      errors++;
      $display("FAIL to_release: got %b required 001", {rsp_valid, rsp_timeout, cmd_ready});
    end
  endtask
`else
  task automatic test_timeout;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h4;
    tick;
    cmd_valid = 1'b0;
    repeat (40) tick;
    checks++;
    if ({bus.ARVALID, rsp_valid, rsp_timeout} !== 3'b100) begin
      errors++;
      $display("FAIL no_to_wait: got %b required 100", {bus.ARVALID, rsp_valid, rsp_timeout});
    end
    bus.ARREADY = 1'b1;
    tick;
    bus.ARREADY = 1'b0;
    bus.RVALID = 1'b1; bus.RDATA = 32'h0000_0033; bus.RRESP = 2'b00;
    tick;
    bus.RVALID = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_timeout} !== {1'b1, 32'h33, 1'b0}) begin
      errors++;
      $display("FAIL no_to_rsp: got v=%b rdata=%h to=%b required v=1 rdata=33 to=0",
               rsp_valid, rsp_rdata, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hA; cmd_wdata = 32'h55; cmd_wstrb = 4'hF;
    tick;
    cmd_valid = 1'b0;
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    tick;
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    checks++;
    if (bus.BREADY !== 1'b1) begin
      errors++;
      $display("FAIL rm_in_wr_resp: got bready=%b required 1", bus.BREADY);
    end
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({bus.BREADY, rsp_valid, cmd_ready} !== 3'b000) begin
      errors++;
      $display("FAIL rm_async_clear: got %b required 000", {bus.BREADY, rsp_valid, cmd_ready});
    end
    bus.BVALID = 1'b1; bus.BRESP = 2'b01;
    tick; tick;
    bus.BVALID = 1'b0;
    ARESETN = 1'b1;
    tick;
    checks++;
    if ({rsp_valid, cmd_ready, bus.BREADY} !== 3'b010) begin
      errors++;
      $display("FAIL rm_after_release: got %b required 010", {rsp_valid, cmd_ready, bus.BREADY});
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h8;
    tick;
    cmd_valid = 1'b0;
    bus.ARREADY = 1'b1;
    tick;
    bus.ARREADY = 1'b0;
    bus.RVALID = 1'b1; bus.RDATA = 32'h0000_0077; bus.RRESP = 2'b00;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_early_rsp: got %b required 0", rsp_valid);
    end
    tick;
    bus.RVALID = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_resp} !== {1'b1, 32'h77, 2'b00}) begin
      errors++;
      $display("FAIL rm_next_cmd: got v=%b rdata=%h resp=%b required v=1 rdata=77 resp=00",
               rsp_valid, rsp_rdata, rsp_resp);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_write_w_first();
    test_error_hold();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi4lite_master.md
AXI4LITE_MASTER -- requirements
Module: axi4lite_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, AXI data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, AXI address width in bits.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, per-transaction watchdog limit in cycles; valid range 2 to 65535.
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as listed below.
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response was produced by the watchdog.
- AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: AXI4-Lite initiator side; widths per AXI4-Lite using ADDR_WIDTH/DATA_WIDTH, WSTRB 4 bits.

Function
REQ-005 SHALL support one outstanding transaction; FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; on handshake capture addr/wdata/wstrb/write and go to WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-007 In WR_ADDR_DATA, SHALL assert AWVALID and WVALID together in the cycle after acceptance, and drop each independently the cycle after its own handshake.
REQ-008 In WR_ADDR_DATA, SHALL move to WR_RESP once both the AW and W handshakes are done, in either order or in the same cycle.
REQ-009 In WR_RESP, SHALL hold BREADY=1; on BVALID SHALL capture BRESP, set rsp_rdata=0 and go to RSP.
REQ-010 In RD_ADDR, SHALL assert ARVALID until ARREADY, then go to RD_DATA with RREADY=1.
REQ-011 In RD_DATA, on RVALID SHALL capture RDATA and RRESP and go to RSP.
REQ-012 AWADDR, ARADDR, WDATA and WSTRB SHALL hold the captured command values from acceptance until the response is produced, not only until the handshake, because responders may sample the address after AW handshake.
REQ-013 In RSP, SHALL assert rsp_valid with stable rsp_* until rsp_ready, then return to IDLE.
REQ-014 Minimum latency from command handshake to rsp_valid SHALL be 3 cycles with a zero-wait responder.
REQ-015 Non-OKAY BRESP/RRESP SHALL be passed through unchanged with rsp_timeout=0.
REQ-016 VALID outputs SHALL never depend combinationally on READY inputs; all AXI outputs SHALL be registered.

Reset
REQ-017 While ARESETN=0, all of the following SHALL be 0 and the FSM SHALL be IDLE: AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_timeout, cmd_ready, rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB.
REQ-018 Reset asserted mid-transaction SHALL abort it immediately with no response; cmd_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-019 Macro AXI4LITE_MASTER_TIMEOUT_EN defined SHALL enable a watchdog counter that starts at command acceptance, counts every cycle until RSP is entered, and clears on RSP entry.
REQ-020 With the macro defined, reaching TIMEOUT_CYCLES SHALL deassert all AXI VALID/READY outputs and enter RSP with rsp_resp=2'b10, rsp_timeout=1 and rsp_rdata=0.
REQ-021 With the macro undefined, there SHALL be no counter, the master SHALL wait indefinitely, and rsp_timeout SHALL be tied to 0.

Verification
REQ-022 Write cmd addr 0x0, wdata 0x000000A5, wstrb 0xF; responder AWREADY 1 cycle after AWVALID, BRESP 00 -> AWADDR=0x0 held through B handshake; rsp_resp=00, rsp_rdata=0.
REQ-023 Read addr 0x8; responder returns RDATA 0x00000002, RRESP 00 after 2 waits -> rsp_rdata=0x00000002, rsp_resp=00, ARADDR stable until RVALID.
REQ-024 Write with WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays high, exactly one B handshake, rsp_valid once.
REQ-025 Read addr 0xC; RRESP 10 and rsp_ready held low 5 cycles -> rsp_valid and rsp_resp=10 stable for all 5 cycles; cmd_ready=0 until the rsp handshake.
REQ-026 Macro defined, TIMEOUT_CYCLES=16, responder never asserts ARREADY -> ARVALID drops; rsp_valid 16 cycles after acceptance with rsp_resp=10, rsp_timeout=1.
REQ-027 ARESETN pulsed low during WR_RESP -> BREADY and rsp_valid 0 immediately; no response emitted; next command accepted normally.
